// File: rtl/pwm_dimmer.sv
`default_nettype none
// ============================================================================
// Module   : pwm_dimmer
// Purpose  : PWM brightness controller driven by one-cycle button pulses.
//            Keeps an OFF/ON state and a brightness level (1..LEVEL_MAX), and
//            drives a fixed-frequency PWM output. The active duty is reloaded
//            only at period boundaries, so the output never shows runt or
//            stretched pulses.
// Ports    : i_clk           - system clock, rising edge
//            i_reset_n       - asynchronous assert, synchronous release, active low
//            i_btn_onoff     - one-cycle pulse, toggles OFF/ON
//            i_btn_up        - one-cycle pulse, level + 1 (ON only, saturating)
//            i_btn_down      - one-cycle pulse, level - 1 (ON only, saturating)
//            o_pwm           - registered PWM drive
//            o_on            - high while in ON
//            o_level         - current brightness level
//            o_period_start  - high in the cycle where the period counter is 0
// Revision : 1.0 - initial release
// ============================================================================
module pwm_dimmer #(
  parameter int PERIOD    = 100_000,
  parameter int LEVEL_MAX = 4
) (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  logic                           i_btn_onoff,
  input  logic                           i_btn_up,
  input  logic                           i_btn_down,
  output logic                           o_pwm,
  output logic                           o_on,
  output logic [$clog2(LEVEL_MAX+1)-1:0] o_level,
  output logic                           o_period_start
);

  localparam int STEP = PERIOD / LEVEL_MAX;
  localparam int CW   = $clog2(PERIOD);
  // One bit wider than the counter when PERIOD is a power of two, so that a
  // full-on duty (LEVEL_MAX * STEP == PERIOD) is representable.
  localparam int DW   = $clog2(PERIOD + 1);
  localparam int LW   = $clog2(LEVEL_MAX + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD - 1);
  localparam logic [LW-1:0] LVL_MAX_C = LW'(LEVEL_MAX);
  localparam logic [LW-1:0] LVL_ONE   = LW'(1);

  typedef enum logic [0:0] {
    ST_OFF = 1'b0,
    ST_ON  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   level_q, level_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [DW-1:0]   duty_q,  duty_d;
  logic            pwm_q,   pwm_d;
  logic [DW-1:0]   target_duty;
  logic            cnt_wrap;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_OFF;
      level_q <= LVL_ONE;
      cnt_q   <= '0;
      duty_q  <= '0;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM and level update. An onoff pulse takes priority and suppresses any
  // up/down pulse in the same cycle; up and down together cancel.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (i_btn_onoff) begin
      state_d = (state_q == ST_ON) ? ST_OFF : ST_ON;
    end else if (state_q == ST_ON) begin
      if (i_btn_up && !i_btn_down && (level_q < LVL_MAX_C)) begin
        level_d = level_q + 1'b1;
      end else if (i_btn_down && !i_btn_up && (level_q > LVL_ONE)) begin
        level_d = level_q - 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Period counter, duty reload and PWM comparator.
  // The target is formed from the registered state/level, so a button press
  // landing on the wrap edge itself is picked up at the following boundary.
  // --------------------------------------------------------------------------
  assign cnt_wrap    = (cnt_q == CNT_LAST);
  assign target_duty = (state_q == ST_ON) ? DW'(int'(level_q) * STEP) : '0;

  always_comb begin
    cnt_d  = cnt_wrap ? '0 : cnt_q + 1'b1;
    duty_d = cnt_wrap ? target_duty : duty_q;
    // Uses pre-edge counter and duty: high time starts the cycle after cnt==0.
    pwm_d  = (DW'(cnt_q) < duty_q);
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_pwm          = pwm_q;
  assign o_on           = (state_q == ST_ON);
  assign o_level        = level_q;
  assign o_period_start = (cnt_q == '0);

endmodule
`default_nettype wire

// File: doc/pwm_dimmer.md
# pwm_dimmer

PWM brightness controller for the light output. Consumes the one-cycle button pulses produced by the debounced button stages: one stage each for on/off, up and down. It keeps an on/off state and a brightness level, and drives a fixed-frequency PWM output. Duty changes take effect only at PWM period boundaries, so the output never shows runt or stretched pulses.

## Interface
- PERIOD, 100_000: PWM period in clocks (1 kHz at 100 MHz). Must be ≥ 2 and an integer multiple of LEVEL_MAX.
- LEVEL_MAX, 4: highest brightness level. Levels run 1..LEVEL_MAX. STEP = PERIOD / LEVEL_MAX clocks of high time per level.
- i_clk, input, 1: system clock. All logic is on the rising edge.
- i_reset_n, input, 1: asynchronous, active-low reset. Assertion is asynchronous; release is synchronous to i_clk.
- i_btn_onoff, input, 1: one-cycle pulse that toggles OFF/ON.
- i_btn_up, input, 1: one-cycle pulse that raises the level by one.
- i_btn_down, input, 1: one-cycle pulse that lowers the level by one.
- o_pwm, output, 1: registered PWM drive.
- o_on, output, 1: 1 while the FSM is in ON.
- o_level, output, $clog2(LEVEL_MAX+1): current brightness level.
- o_period_start, output, 1: high during the single cycle in which the period counter is 0.

## Operation
- FSM states:
  - OFF: reset state.
  - ON: entered from OFF on an i_btn_onoff pulse.
  - ON → OFF on an i_btn_onoff pulse.
- Level register:
  - Reset value is 1.
  - The level is retained across OFF/ON toggles.
- Level changes, applied only in ON:
  - up alone: level = min(level+1, LEVEL_MAX).
  - down alone: level = max(level−1, 1).
- Level changes in OFF: up and down are ignored.
- Simultaneous pulses in the same cycle:
  - onoff is processed; up and down are ignored that cycle.
  - up together with down gives no change.
- Period counter:
  - r_cnt counts 0..PERIOD−1 and wraps to 0.
  - It free-runs in both states.
  - Width is $clog2(PERIOD).
- Target duty: level×STEP when ON, 0 when OFF.
  - Compute it at width ≥ $clog2(PERIOD+1), so that LEVEL_MAX×STEP = PERIOD fits.
- Active duty register r_duty:
  - Loads the target duty on the edge where r_cnt == PERIOD−1, together with the wrap of r_cnt to 0.
  - It holds at every other time.
  - Reset value is 0.
- o_pwm:
  - On each edge, o_pwm <= (r_cnt < r_duty), using pre-edge values.
  - Result: exactly r_duty high cycles per period, starting the cycle after r_cnt == 0.
  - Duty PERIOD gives constant high. Duty 0 gives constant low.
- Turning OFF mid-period: the current period completes at its old duty, then the output goes low.
- Turning ON mid-period: the output stays low until the next boundary.

## Timing
- Reset values while i_reset_n = 0:
  - o_pwm = 0, o_on = 0, o_level = 1.
  - r_cnt = 0, so o_period_start = 1.
  - r_duty = 0, state = OFF.
- Reset asserted mid-period:
  - All outputs take their reset values immediately (asynchronously).
  - After release, r_cnt starts from 0.
- Button latency: a pulse sampled at edge k updates o_on and o_level at edge k (visible in cycle k+1).
- Duty latency:
  - A new target is applied at the first r_cnt == PERIOD−1 edge at or after the update.
  - It appears on o_pwm one cycle after r_cnt == 0.
  - Worst case is PERIOD+1 cycles.
- Pulse width: input pulses are assumed to be one cycle wide. A pulse held for N cycles counts as N presses.
- Combinational paths: o_period_start is decoded combinationally from r_cnt. All other outputs are direct register outputs.

## Test plan
Run all scenarios with PERIOD = 8 and LEVEL_MAX = 4, so STEP = 2.

- Reset, no buttons -> o_on = 0, o_level = 1, and o_pwm stays 0 for 5 periods. o_period_start pulses every 8 cycles.
- onoff pulse mid-period -> o_on = 1 the next cycle. o_pwm stays 0 until the boundary, then reads 1,1,0,0,0,0,0,0 each period.
- Five up pulses while ON -> o_level steps 2, 3, 4, 4, 4. High time per period becomes 8/8 (constant high) from the next boundary.
- Then five down pulses -> o_level reaches 1 and saturates there, giving 2/8 high. An up pulse while OFF -> o_level unchanged.
- up and down in the same cycle -> no level change. onoff together with up -> toggles state, and the level is unchanged.
- Reset pulse at r_cnt = 3 while o_pwm = 1 -> o_pwm falls to 0 with no clock edge, and o_level = 1. After release, o_pwm stays 0 and the FSM is in OFF.
